regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the 16/32-entry mMIPS register file.
- Configurable data width, depth and number of read ports.
- Optional write-to-read bypass, so a same-cycle write is visible to readers.
- Hardware-sequenced clear after reset or on request, making it RAM-friendly (no parallel reset of the array).
- Sits in the decode stage; feeds the ALU operand muxes.

Parameters:
- DWIDTH, 32: data word width in bits (matches `DWORD`).
- AWIDTH, 5: address width; depth = 2**AWIDTH entries.
- NREAD, 2: number of independent read ports.
- ZERO_REG, 1: 1 = entry 0 is hard-wired to zero and writes to it are dropped.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk     in   1              rising-edge clock
- rst     in   1              asynchronous, active-high reset
- clr     in   1              synchronous request to re-clear the whole array
- ready   out  1              1 = clear finished; reads and writes are valid
- r_addr  in   NREAD*AWIDTH   packed read addresses; port k uses bits [k*AWIDTH +: AWIDTH]
- r_data  out  NREAD*DWIDTH   packed read data; port k uses bits [k*DWIDTH +: DWIDTH]
- w_addr  in   AWIDTH         write address
- w_data  in   DWIDTH         write data
- w       in   1              write enable

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Clear FSM has two states, CLEAR and RUN, and a counter cnt of AWIDTH bits.
- rst asserted (async): state <= CLEAR, cnt <= 0, ready <= 0. Array contents are not reset directly.
- CLEAR, each clk: regs[cnt] <= 0; cnt <= cnt+1.
  - When cnt == 2**AWIDTH-1, that entry is written and state <= RUN, ready <= 1.
  - Clear takes exactly 2**AWIDTH cycles (32 at defaults) after rst deasserts.
- RUN with clr=1 at a clk edge: state <= CLEAR, cnt <= 0, ready <= 0 (registered, effective the next cycle).
  - A write presented in the same cycle as clr is dropped.
- clr asserted during CLEAR: cnt restarts at 0.
- rst mid-clear: FSM restarts CLEAR from cnt=0.
- Write, RUN only: at posedge, if w=1, regs[w_addr] <= w_data.
  - If ZERO_REG=1 and w_addr==0, the write is ignored.
  - During CLEAR, w is ignored entirely.
- Read is combinational, zero latency. For each port k: r_data_k = regs[r_addr_k], with these overrides in priority order:
  1. ready=0: r_data_k = 0.
  2. ZERO_REG=1 and r_addr_k==0: r_data_k = 0.
  3. BYPASS=1 and w=1 and w_addr==r_addr_k (and the write is not dropped by ZERO_REG): r_data_k = w_data.
  4. Otherwise the stored value.
- With BYPASS=0, a read returns the old value until the edge after the write.
- All read ports may address the same entry simultaneously; each gets an identical result.
- No output is X after rst; ready resets to 0.

Decomposition:
- Shared defines file (mmips_defines.v):
  - default DWIDTH from `DWORD;
  - `REGF_CLEAR / `REGF_RUN state encodings (1 bit).
- Sub-module regfile_clear_fsm:
  - inputs clk, rst, clr; outputs ready, clr_we, clr_addr[AWIDTH-1:0];
  - the top muxes clr_addr/0 onto the array write port while clr_we=1.
- Read ports are built with a generate loop over NREAD.

Test Plan:
1. Reset and clear timing: deassert rst at t0.
   - ready=0 for exactly 32 cycles, then ready=1.
   - Every address reads 0x00000000 afterwards.
2. Write then read, BYPASS=1:
   - Cycle n: w=1, w_addr=5, w_data=0xDEADBEEF, r_addr port0=5 → r_data0=0xDEADBEEF in cycle n (bypass).
   - Cycle n+1, w=0 → still 0xDEADBEEF.
3. Zero register:
   - w=1, w_addr=0, w_data=0x12345678, both ports read address 0 → r_data=0 in the same and all later cycles.
4. Dual port: regs[3]=0xA, regs[7]=0xB; r_addr={7,3} → r_data0=0xA, r_data1=0xB in the same cycle.
5. Mid-operation clear:
   - Fill regs[1..31] with their index, pulse clr → ready=0 next cycle.
   - A write during clear is ignored.
   - After 32 cycles, ready=1 and all entries read 0.
6. Async reset mid-clear:
   - Assert rst at clear cycle 10, between clock edges → ready stays 0 immediately.
   - After release, clear takes the full 32 cycles.
   - With BYPASS=0 (second build), a same-cycle write/read returns the old value and the new value one cycle later.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_mp_pkg;

  localparam int DWORD = 32;

  typedef enum logic {
    REGF_CLEAR = 1'b0,
    REGF_RUN   = 1'b1
  } regf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequences a zero write through every entry after reset or a clr request.
// Clear walk is 2**AWIDTH cycles; ready is registered and drops the cycle after clr.
module regfile_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr
);

  regf_state_e       state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      REGF_CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
          // Last entry is written on this edge, so the array is usable next cycle.
          if (cnt_q == {AWIDTH{1'b1}}) begin
            state_d = REGF_RUN;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        if (clr) begin
          state_d = REGF_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REGF_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == REGF_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD combinational read ports, one write port.
// Zero-latency reads with optional same-cycle bypass; writes ignored while clearing.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DWIDTH   = DWORD,
  parameter int AWIDTH   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    ready,
  input  logic [NREAD*AWIDTH-1:0] r_addr,
  output logic [NREAD*DWIDTH-1:0] r_data,
  input  logic [AWIDTH-1:0]       w_addr,
  input  logic [DWIDTH-1:0]       w_data,
  input  logic                    w
);

  localparam int DEPTH = 1 << AWIDTH;

  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;

  regfile_clear_fsm #(
    .AWIDTH(AWIDTH)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DWIDTH-1:0] regs_q [DEPTH];
  logic              w_ok;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdat;

  always_comb begin
    w_ok     = w && !((ZERO_REG != 0) && (w_addr == '0));
    // A write coinciding with a clr request is dropped; the clear wins.
    mem_we   = clr_we || (ready && !clr && w_ok);
    mem_addr = clr_we ? clr_addr : w_addr;
    mem_wdat = clr_we ? '0 : w_data;
  end

  // No reset on the array so it can map onto RAM; the clear FSM zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs_q[mem_addr] <= mem_wdat;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    logic [DWIDTH-1:0] rd;

    assign ra = r_addr[k*AWIDTH +: AWIDTH];

    always_comb begin
      if (!ready) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && w_ok && (w_addr == ra)) begin
        rd = w_data;
      end else begin
        rd = regs_q[ra];
      end
    end

    assign r_data[k*DWIDTH +: DWIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing and a non-bypassing register file driven in lockstep.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [9:0]  r_addr;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w;
  logic        ready_a, ready_b;
  logic [63:0] r_data_a, r_data_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_a),
    .r_addr(r_addr), .r_data(r_data_a),
    .w_addr(w_addr), .w_data(w_data), .w(w)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_b),
    .r_addr(r_addr), .r_data(r_data_b),
    .w_addr(w_addr), .w_data(w_data), .w(w)
  );

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic [31:0] eb1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises, bounded so a stuck DUT still ends the run.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_a && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      r_addr = {5'(31 - i), 5'(i)};
      #1;
      chk({name, "_a0"}, r_data_a[31:0], 32'h0);
      chk({name, "_a1"}, r_data_a[63:32], 32'h0);
      chk({name, "_b0"}, r_data_b[31:0], 32'h0);
      chk({name, "_b1"}, r_data_b[63:32], 32'h0);
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd3,  32'hA,        5'd3,  5'd7,  32'hA,        32'h0,        32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'hB,        5'd3,  5'd7,  32'hA,        32'hB,        32'hA,        32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  32'hA,        32'hB,        32'hA,        32'hB};
    vecs[7] = '{1'b1, 5'd5,  32'h55,       5'd5,  5'd3,  32'h55,       32'hA,        32'hDEADBEEF, 32'hA};
    vecs[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hFFFFFFFF, 32'h55,       32'hFFFFFFFF, 32'h55};

    rst = 1'b1; clr = 1'b0; w = 1'b0; w_addr = '0; w_data = '0;
    r_addr = {5'd9, 5'd4};
    #12;
    chk("rst_ready_a", 32'(ready_a), 32'h0);
    chk("rst_ready_b", 32'(ready_b), 32'h0);
    chk("rst_rdata_a", r_data_a[31:0], 32'h0);
    chk("rst_rdata_b", r_data_b[63:32], 32'h0);

    step();
    rst = 1'b0;
    wait_ready(n);
    chk("init_clear_cycles", 32'(n), 32'd32);
    chk("init_ready_b", 32'(ready_b), 32'h1);
    read_all_zero("init_zero");

    for (int i = 0; i < 10; i++) begin
      w = vecs[i].w; w_addr = vecs[i].wa; w_data = vecs[i].wd;
      r_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d_a0", i), r_data_a[31:0],  vecs[i].ea0);
      chk($sformatf("vec%0d_a1", i), r_data_a[63:32], vecs[i].ea1);
      chk($sformatf("vec%0d_b0", i), r_data_b[31:0],  vecs[i].eb0);
      chk($sformatf("vec%0d_b1", i), r_data_b[63:32], vecs[i].eb1);
      step();
    end
    w = 1'b0;

    // Fill entries 1..31 with their own index, then re-clear on request.
    for (int i = 1; i < 32; i++) begin
      w = 1'b1; w_addr = 5'(i); w_data = 32'(i);
      step();
    end
    w = 1'b0;
    r_addr = {5'd31, 5'd17};
    #1;
    chk("fill_a0", r_data_a[31:0], 32'd17);
    chk("fill_b1", r_data_b[63:32], 32'd31);

    clr = 1'b1; w = 1'b1; w_addr = 5'd9; w_data = 32'h99;
    step();
    clr = 1'b0;
    chk("clr_ready_a", 32'(ready_a), 32'h0);
    chk("clr_ready_b", 32'(ready_b), 32'h0);
    w_addr = 5'd2; w_data = 32'h77;
    #1;
    chk("clr_rdata_a", r_data_a[31:0], 32'h0);
    chk("clr_rdata_b", r_data_b[63:32], 32'h0);
    wait_ready(n);
    w = 1'b0;
    chk("clr_cycles", 32'(n), 32'd32);
    chk("clr_ready_b_done", 32'(ready_b), 32'h1);
    read_all_zero("clr_zero");

    // Reset landing in the middle of a clear restarts the full walk.
    w = 1'b1; w_addr = 5'd12; w_data = 32'h1234;
    step();
    w = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready_a", 32'(ready_a), 32'h0);
    chk("arst_ready_b", 32'(ready_b), 32'h0);
    step();
    rst = 1'b0;
    wait_ready(n);
    chk("arst_clear_cycles", 32'(n), 32'd32);
    chk("arst_ready_b", 32'(ready_b), 32'h1);
    read_all_zero("arst_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
